// File: rtl/instruction_encoder.sv
// Encodes instruction fields into 32-bit words, queued in a 2-entry output FIFO.
// Immediate range checking is compiled in only when ENCODER_RANGE_CHECK_EN is defined.
package instruction_encoder_pkg;
  localparam logic [6:0] IType      = 7'b0010011;
  localparam logic [6:0] ITypeLoad  = 7'b0000011;
  localparam logic [6:0] ITypeJALR  = 7'b1100111;
  localparam logic [6:0] SType      = 7'b0100011;
  localparam logic [6:0] BType      = 7'b1100011;
  localparam logic [6:0] UType      = 7'b0110111;
  localparam logic [6:0] UTypeAUIPC = 7'b0010111;
  localparam logic [6:0] JType      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;
endpackage

module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [31:0]            immediate,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [31:0]            outInstruction,
  output logic                   rangeError,
  output logic [COUNT_WIDTH-1:0] encodedCount,
  output logic [COUNT_WIDTH-1:0] errorCount
);

  localparam int DEPTH = 2;

  fmt_e                   fmt;
  logic [31:0]            field_bits;
  logic [31:0]            imm_bits;
  logic [31:0]            enc_word;
  logic                   range_err;
  logic                   push;
  logic                   pop;
  logic [1:0]             occupancy_reg;
  logic [1:0]             occupancy_next;
  logic                   wr_ptr_reg;
  logic                   rd_ptr_reg;
  logic [COUNT_WIDTH-1:0] encoded_count_reg;
  logic [31:0]            word_mem [DEPTH];

  always_comb begin
    case (opcode)
      IType, ITypeLoad, ITypeJALR: fmt = FMT_I;
      SType:                       fmt = FMT_S;
      BType:                       fmt = FMT_B;
      UType, UTypeAUIPC:           fmt = FMT_U;
      JType:                       fmt = FMT_J;
      default:                     fmt = FMT_R;
    endcase
  end

  // Register/function fields; each format keeps only the fields it carries.
  always_comb begin
    field_bits       = '0;
    field_bits[6:0]  = opcode;
    if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) begin
      field_bits[11:7] = rd;
    end
    if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
      field_bits[14:12] = funct3;
      field_bits[19:15] = rs1;
    end
    if (fmt inside {FMT_R, FMT_S, FMT_B}) begin
      field_bits[24:20] = rs2;
    end
    if (fmt == FMT_R) begin
      field_bits[31:25] = funct7;
    end
  end

  // B and J immediates arrive without their implicit zero LSB, so bit k here is offset k+1.
  always_comb begin
    imm_bits = '0;
    case (fmt)
      FMT_I: begin
        imm_bits[31:20] = immediate[11:0];
      end
      FMT_S: begin
        imm_bits[31:25] = immediate[11:5];
        imm_bits[11:7]  = immediate[4:0];
      end
      FMT_B: begin
        imm_bits[31]    = immediate[11];
        imm_bits[7]     = immediate[10];
        imm_bits[30:25] = immediate[9:4];
        imm_bits[11:8]  = immediate[3:0];
      end
      FMT_U: begin
        imm_bits[31:12] = immediate[19:0];
      end
      FMT_J: begin
        imm_bits[31]    = immediate[19];
        imm_bits[19:12] = immediate[18:11];
        imm_bits[20]    = immediate[10];
        imm_bits[30:21] = immediate[9:0];
      end
      default: begin
        imm_bits = '0;
      end
    endcase
  end

  assign enc_word = field_bits | imm_bits;

`ifdef ENCODER_RANGE_CHECK_EN
  logic                   err_mem [DEPTH];
  logic [COUNT_WIDTH-1:0] error_count_reg;

  // Signed immediates fit when every bit above the field's sign bit matches it.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S, FMT_B: range_err = !((&immediate[31:11]) || !(|immediate[31:11]));
      FMT_J:               range_err = !((&immediate[31:19]) || !(|immediate[31:19]));
      FMT_U:               range_err = |immediate[31:20];
      default:             range_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      err_mem[wr_ptr_reg] <= range_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_count_reg <= '0;
    end else if (push && range_err) begin
      error_count_reg <= error_count_reg + COUNT_WIDTH'(1);
    end
  end

  assign rangeError = outValid ? err_mem[rd_ptr_reg] : 1'b0;
  assign errorCount = error_count_reg;
`else
  logic unused_imm_hi;

  assign range_err     = 1'b0;
  assign unused_imm_hi = ^{immediate[31:20], range_err};
  assign rangeError    = 1'b0;
  assign errorCount    = '0;
`endif

  // Acceptance depends only on occupancy so upstream never waits on the consumer.
  assign inReady  = (occupancy_reg < 2'(DEPTH));
  assign outValid = (occupancy_reg != 2'd0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_comb begin
    occupancy_next = occupancy_reg;
    case ({push, pop})
      2'b10:   occupancy_next = occupancy_reg + 2'd1;
      2'b01:   occupancy_next = occupancy_reg - 2'd1;
      default: occupancy_next = occupancy_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy_reg     <= '0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      encoded_count_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
      if (push) begin
        wr_ptr_reg        <= ~wr_ptr_reg;
        encoded_count_reg <= encoded_count_reg + COUNT_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= enc_word;
    end
  end

  // Gating by outValid gives a zero word while empty, including straight out of reset.
  assign outInstruction = outValid ? word_mem[rd_ptr_reg] : 32'd0;
  assign encodedCount   = encoded_count_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized self-checking bench for instruction_encoder against a queue-based reference model.
module tb_instruction_encoder;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immediate;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstruction;
  logic        rangeError;
  logic [15:0] encodedCount;
  logic [15:0] errorCount;

  instruction_encoder #(.COUNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .inValid       (inValid),
    .inReady       (inReady),
    .opcode        (opcode),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .funct3        (funct3),
    .funct7        (funct7),
    .immediate     (immediate),
    .outValid      (outValid),
    .outReady      (outReady),
    .outInstruction(outInstruction),
    .rangeError    (rangeError),
    .encodedCount  (encodedCount),
    .errorCount    (errorCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] w;
    logic        e;
  } ent_t;

  ent_t        q[$];
  logic [15:0] exp_enc;
  logic [15:0] exp_err;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: word and range flag computed arithmetically from the field rules.
  function automatic ent_t ref_encode(input logic [6:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] im);
    ent_t        r;
    byte         f;
    logic [31:0] o, dd, a, b, c3, c7;
    int          s;
    o  = 32'(op);
    dd = 32'(d);
    a  = 32'(s1);
    b  = 32'(s2);
    c3 = 32'(f3);
    c7 = 32'(f7);
    s  = int'(im);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: f = "I";
      7'b0100011:                         f = "S";
      7'b1100011:                         f = "B";
      7'b0110111, 7'b0010111:             f = "U";
      7'b1101111:                         f = "J";
      default:                            f = "R";
    endcase
    r.e = 1'b0;
    case (f)
      "I": begin
        r.w = o | (dd << 7) | (c3 << 12) | (a << 15) | ((im & 32'hFFF) << 20);
        r.e = (s < -2048) || (s > 2047);
      end
      "S": begin
        r.w = o | ((im & 32'h1F) << 7) | (c3 << 12) | (a << 15) | (b << 20)
            | (((im >> 5) & 32'h7F) << 25);
        r.e = (s < -2048) || (s > 2047);
      end
      "B": begin
        r.w = o | (((im >> 11) & 32'h1) << 31) | (((im >> 10) & 32'h1) << 7)
            | (((im >> 4) & 32'h3F) << 25) | ((im & 32'hF) << 8)
            | (c3 << 12) | (a << 15) | (b << 20);
        r.e = (s < -2048) || (s > 2047);
      end
      "U": begin
        r.w = o | (dd << 7) | ((im & 32'hFFFFF) << 12);
        r.e = (im > 32'hFFFFF);
      end
      "J": begin
        r.w = o | (dd << 7) | (((im >> 19) & 32'h1) << 31) | (((im >> 11) & 32'hFF) << 12)
            | (((im >> 10) & 32'h1) << 20) | ((im & 32'h3FF) << 21);
        r.e = (s < -524288) || (s > 524287);
      end
      default: begin
        r.w = o | (dd << 7) | (c3 << 12) | (a << 15) | (b << 20) | (c7 << 25);
      end
    endcase
`ifndef ENCODER_RANGE_CHECK_EN
    r.e = 1'b0;
`endif
    return r;
  endfunction

  task automatic drive_req(input logic v, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
    inValid   = v;
    opcode    = op;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    funct3    = f3;
    funct7    = f7;
    immediate = im;
  endtask

  // Compare outputs against the model, then advance one clock and update the model.
  task automatic tick();
    logic do_push, do_pop;
    ent_t n;
    check("in_ready", inReady, q.size() < 2);
    check("out_valid", outValid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_word", outInstruction, q[0].w);
      check("range_err", rangeError, q[0].e);
    end
    check("enc_count", encodedCount, exp_enc);
    check("err_count", errorCount, exp_err);
    do_push = inValid && (q.size() < 2);
    do_pop  = outReady && (q.size() > 0);
    n = ref_encode(opcode, rd, rs1, rs2, funct3, funct7, immediate);
    @(posedge clk);
    #1;
    if (do_pop) begin
      $display("pop  word=%08h err=%0b", q[0].w, q[0].e);
      void'(q.pop_front());
    end
    if (do_push) begin
      q.push_back(n);
      exp_enc = exp_enc + 16'd1;
      if (n.e) exp_err = exp_err + 16'd1;
    end
  endtask

  task automatic directed(input string tag, input logic [6:0] op, input logic [4:0] d,
                          input logic [4:0] s1, input logic [31:0] im,
                          input logic [31:0] exp_word, input logic exp_e);
    outReady = 1'b0;
    drive_req(1'b1, op, d, s1, 5'd0, 3'd0, 7'd0, im);
    tick();
    inValid = 1'b0;
    check({tag, "_valid"}, outValid, 1'b1);
    check({tag, "_word"}, outInstruction, exp_word);
    check({tag, "_err"}, rangeError, exp_e);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic rand_req(input logic v);
    logic [6:0]  op;
    logic [31:0] im;
    logic [31:0] edges [10];
    edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'h7FFFF,
              32'h80000, 32'hFFF80000, 32'hFFF7FFFF, 32'hFFFFF, 32'h100000};
    case ($urandom_range(0, 9))
      0: op = 7'b0010011;
      1: op = 7'b0000011;
      2: op = 7'b1100111;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b0110111;
      6: op = 7'b0010111;
      7: op = 7'b1101111;
      8: op = 7'b0110011;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: im = $urandom;
      1: im = 32'(int'($urandom_range(0, 4095)) - 2048);
      2: im = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      default: im = edges[$urandom_range(0, 9)];
    endcase
    drive_req(v, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im);
  endtask

  logic [15:0] enc_before;
  logic        exp_range;

  initial begin
    total   = 0;
    bad     = 0;
    exp_enc = '0;
    exp_err = '0;
    reset   = 1'b1;
    outReady = 1'b0;
    drive_req(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
`ifdef ENCODER_RANGE_CHECK_EN
    exp_range = 1'b1;
`else
    exp_range = 1'b0;
`endif
    #12;
    check("rst_out_valid", outValid, 1'b0);
    check("rst_in_ready", inReady, 1'b1);
    check("rst_word", outInstruction, 32'd0);
    check("rst_enc", encodedCount, 16'd0);
    check("rst_err", errorCount, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    directed("i_type", 7'b0010011, 5'd1, 5'd2, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
    directed("u_type", 7'b0110111, 5'd5, 5'd0, 32'h00012345, 32'h123452B7, 1'b0);
    directed("j_type", 7'b1101111, 5'd0, 5'd0, 32'h00000004, 32'h0080006F, 1'b0);
    directed("range", 7'b0010011, 5'd0, 5'd0, 32'h00000800, 32'h80000013, exp_range);
    check("range_err_count", errorCount, 16'(exp_range));

    // Backpressure: third request waits until one pop has freed a slot.
    outReady = 1'b0;
    rand_req(1'b1);
    tick();
    rand_req(1'b1);
    tick();
    rand_req(1'b1);
    check("bp_third_blocked", inReady, 1'b0);
    tick();
    outReady = 1'b1;
    tick();
    tick();
    inValid = 1'b0;
    tick();
    tick();
    check("bp_drained", outValid, 1'b0);

    // Simultaneous push and pop holding occupancy at one.
    outReady = 1'b0;
    rand_req(1'b1);
    tick();
    enc_before = encodedCount;
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_req(1'b1);
      tick();
    end
    check("sim_count", encodedCount, enc_before + 16'd10);
    check("sim_occ_valid", outValid, 1'b1);
    inValid = 1'b0;
    tick();

    // Reset with two entries queued, then a request held across a reset edge.
    outReady = 1'b0;
    rand_req(1'b1);
    tick();
    rand_req(1'b1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", outValid, 1'b0);
    check("mid_rst_ready", inReady, 1'b1);
    check("mid_rst_enc", encodedCount, 16'd0);
    check("mid_rst_err", errorCount, 16'd0);
    check("mid_rst_word", outInstruction, 32'd0);
    q.delete();
    exp_enc = '0;
    exp_err = '0;
    drive_req(1'b1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd2, 7'd0, 32'd5);
    @(posedge clk);
    #1;
    check("rst_no_accept", encodedCount, 16'd0);
    check("rst_no_valid", outValid, 1'b0);
    reset = 1'b0;
    tick();
    inValid = 1'b0;
    check("post_rst_word", outInstruction, 32'h00522193);
    outReady = 1'b1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      rand_req($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      tick();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of encodedCount and errorCount.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port inValid, input, 1, request holds a field set to encode.
REQ-005 SHALL have port inReady, output, 1, encoder accepts a request this cycle.
REQ-006 SHALL have fields opcode [6:0], rd [4:0], rs1 [4:0], rs2 [4:0], funct3 [2:0], funct7 [6:0], all inputs.
REQ-007 SHALL have port immediate, input, 32, immediate in decode-stage form (B and J values exclude the implicit LSB zero; U value right-aligned).
REQ-008 SHALL have port outValid, output, 1, outInstruction is valid.
REQ-009 SHALL have port outReady, input, 1, consumer takes the head entry.
REQ-010 SHALL have port outInstruction, output, 32, encoded instruction word.
REQ-011 SHALL have port rangeError, output, 1, immediate of the head entry was not representable.
REQ-012 SHALL have ports encodedCount and errorCount, outputs, COUNT_WIDTH, running totals.

Function
REQ-013 SHALL select format from opcode using package constants: IType/ITypeLoad/ITypeJALR -> I, SType -> S, BType -> B, UType/UTypeAUIPC -> U, JType -> J, any other -> R.
REQ-014 SHALL pack bits [6:0] opcode; rd at [11:7] for R/I/U/J; funct3 at [14:12] and rs1 at [19:15] for R/I/S/B; rs2 at [24:20] for R/S/B; funct7 at [31:25] for R.
REQ-015 SHALL pack the immediate: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[11]->[31], imm[10]->[7], imm[9:4]->[30:25], imm[3:0]->[11:8]; U imm[19:0]->[31:12]; J imm[19]->[31], imm[18:11]->[19:12], imm[10]->[20], imm[9:0]->[30:21].
REQ-016 SHALL flag out-of-range when: I/S/B imm[31:11] not all equal; J imm[31:19] not all equal; U imm[31:20] nonzero; R never; truncated word is still emitted.
REQ-017 SHALL accept a request when inValid and inReady are both high at a rising edge; inReady = (occupancy < 2), independent of outReady.
REQ-018 SHALL store each accepted word plus its error bit in a 2-entry FIFO; outValid = (occupancy > 0); outInstruction/rangeError show the head entry.
REQ-019 SHALL have latency 1: a request accepted into an empty FIFO gives outValid high the following cycle.
REQ-020 SHALL pop the head when outValid and outReady are high; simultaneous push and pop leaves occupancy unchanged and preserves order.
REQ-021 SHALL keep outInstruction and rangeError stable while outValid is high and outReady is low.
REQ-022 SHALL increment encodedCount per accepted request and errorCount per accepted out-of-range request, both wrapping at 2^COUNT_WIDTH.

Reset
REQ-023 SHALL on reset clear occupancy, read/write pointers, encodedCount and errorCount, forcing outValid=0, inReady=1, outInstruction=0, rangeError=0 immediately, discarding in-flight entries.
REQ-024 SHALL accept no request in any cycle reset is high.

Configuration
REQ-025 SHALL use macro ENCODER_RANGE_CHECK_EN: defined -> REQ-016 checking, rangeError and errorCount active; undefined -> no checking logic, rangeError and errorCount tied to 0.

Verification
REQ-026 I-type: opcode 0010011, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF -> outInstruction 0xFFF10093, rangeError=0, outValid one cycle after accept.
REQ-027 U-type: opcode 0110111, rd=5, imm=0x00012345 -> 0x123452B7; J-type: opcode 1101111, rd=0, imm=0x00000004 -> 0x0080006F.
REQ-028 Range (macro defined): I-type opcode 0010011, rd=0, rs1=0, imm=0x00000800 -> 0x80000013, rangeError=1, errorCount=1; macro undefined -> rangeError=0.
REQ-029 Backpressure: outReady=0, three back-to-back requests -> two accepted, inReady=0 on third; outReady=1 -> entries drain in order, third accepted the cycle after the first pop.
REQ-030 Simultaneous push/pop at occupancy 1 for 10 cycles -> occupancy stays 1, encodedCount=10 more, no word lost or reordered.
REQ-031 Reset asserted with 2 entries queued -> outValid=0, inReady=1 and counts=0 without a clock edge; first post-reset request encodes correctly.
